rv32_fetch_unit: RTL and testbench
==================================

// Module: rv32_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the rv32 core's `instruction` input.
//  Owns the fetch PC and issues sequential word fetches to instruction memory over a req/gnt/rvalid bus.
//  Buffers returned words with their PCs in a DEPTH-entry prefetch FIFO.
//  Presents them to the core with a valid/ready handshake; a redirect (branch/jump) flushes the stream.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  first fetch address after reset
//  DEPTH         4              prefetch FIFO entries; power of 2, >=2; also max in-flight requests
// PORTS
//  Clocking: one clock; reset is synchronous and active-high (ports clk, reset).
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous reset, active-high
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch byte address, bits[1:0] always 0
//  imem_gnt       in   1   request accepted this cycle (only meaningful while imem_req=1)
//  imem_rvalid    in   1   read data valid; responses in order, >=1 cycle after gnt
//  imem_rdata     in   32  instruction word
//  instr_valid    out  1   FIFO head valid toward core
//  instr_ready    in   1   core consumes head this cycle
//  instr          out  32  head instruction word
//  instr_pc       out  32  byte address of head instruction
//  redirect_valid in   1   flush and restart fetch at redirect_pc
//  redirect_pc    in   32  new fetch address; bits[1:0] forced to 0
// BEHAVIOUR
//  Reset values:
//   - fetch_pc=resp_pc=RESET_VECTOR; FIFO count=0; outstanding=0; drop_cnt=0.
//   - imem_req=0 and instr_valid=0 during reset; instr, instr_pc are don't-care while instr_valid=0.
//  Issue (imem_req):
//   - imem_req = !reset && !redirect_valid && (count+outstanding < DEPTH); combinational.
//   - imem_addr = fetch_pc.
//   - req may drop without gnt (legal on this bus).
//   - req&&gnt: fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstanding++.
//  Response:
//   - rvalid with drop_cnt>0: word discarded; drop_cnt--, outstanding--.
//   - rvalid with drop_cnt==0: push {rdata, resp_pc}; resp_pc += 4; outstanding--.
//   - Space is reserved at issue, so a push never overflows.
//   - Pushed word visible on instr_valid the next cycle (no bypass).
//  Handshake:
//   - instr_valid = (count!=0) && !redirect_valid.
//   - Pop when instr_valid && instr_ready; head stays stable while valid && !ready.
//   - Push+pop in the same cycle: count unchanged; FIFO order preserved.
//  Redirect (highest priority):
//   - FIFO flushed (count=0); fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
//   - drop_cnt = outstanding after this cycle's rvalid; an rvalid in the redirect cycle is discarded.
//   - No gnt is possible that cycle (req low).
//   - First post-redirect request is issued the following cycle.
//  Widths: count and outstanding are $clog2(DEPTH)+1 bits; drop_cnt same width.
//  Reset mid-operation:
//   - All counters are cleared; in-flight responses are forgotten.
//   - Imem shares reset, so no stale rvalid follows reset.
// TESTING
//  1. Reset release, gnt=1, rvalid 1 cycle after gnt, ready=1
//     -> instr_pc 0,4,8,12...; first instr_valid 2 cycles after first gnt.
//  2. DEPTH=4, instr_ready=0 -> exactly 4 gnts then imem_req=0, instr_valid=1 held on pc 0;
//     set ready=1 -> pcs 0,4,8,12,16 in order, no gaps or duplicates.
//  3. Two requests outstanding, redirect_pc=0x100
//     -> both late rvalids dropped; next instr_valid carries instr_pc=0x100 with data of addr 0x100.
//  4. redirect_pc=0x102 -> imem_addr=0x100 next cycle; instr_pc=0x100.
//  5. RESET_VECTOR=0xFFFF_FFF8 -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6. Reset asserted with FIFO full and 2 outstanding -> next cycle instr_valid=0, imem_req=0;
//     after release, fetch restarts at RESET_VECTOR.
//  7. Redirect coincident with rvalid and a pop -> popped word not consumed (instr_valid=0);
//     the rvalid word is discarded.

Source files
------------

// File: rtl/rv32_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues sequential word fetches on a
// req/gnt/rvalid bus and buffers returned words with their PCs for the core.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];

    logic [CW:0]   w_inflight;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_after_rv;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_redirect_aligned;
    logic          w_unused_pc_lsbs;

    // FIFO slots are reserved at issue time, so in-flight requests count against DEPTH.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req   = !reset && !redirect_valid && (w_inflight < DEPTH_W);
    assign imem_addr  = r_fetch_pc;
    assign w_issue    = imem_req && imem_gnt;

    assign instr_valid = (r_count != '0) && !redirect_valid && !reset;
    assign instr       = r_mem_instr[r_rptr];
    assign instr_pc    = r_mem_pc[r_rptr];
    assign w_pop       = instr_valid && instr_ready;

    assign w_push = imem_rvalid && (r_drop_cnt == '0) && !redirect_valid;

    assign w_out_after_rv     = imem_rvalid ? (r_outstanding - CW'(1)) : r_outstanding;
    assign w_out_next         = w_issue ? (w_out_after_rv + CW'(1)) : w_out_after_rv;
    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsbs   = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_VECTOR;
            r_resp_pc     <= RESET_VECTOR;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle's rvalid belongs to the old stream.
            r_fetch_pc    <= w_redirect_aligned;
            r_resp_pc     <= w_redirect_aligned;
            r_count       <= '0;
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_out_after_rv;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wptr    <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (imem_rvalid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= r_resp_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        w_push |-> (r_count != CW'(DEPTH)));

    a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Scoreboarded random + directed bench for rv32_fetch_unit with a latency-randomised
// in-order memory model; expected stream = sequential PCs from each reset/redirect target.
module tb_rv32_fetch_unit;

    localparam logic [31:0] RV    = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    rv32_fetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_head;
    logic [31:0] pending[$];
    logic [31:0] next_pc;
    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    int          gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
    int          redir_permil = 0, rst_permil = 0, rst_cycles = 0;
    bit          redir_now = 1'b0;
    logic [31:0] redir_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A17_C3E5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        next_pc = pc;
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back({next_pc, mem_word(next_pc)});
            next_pc = next_pc + 32'd4;
        end
    endtask

    // One bus/core cycle: drive just after the rising edge, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        instr_ready = ($urandom_range(99) < rdy_pct);
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        if (rst_cycles > 0) begin
            rst_cycles--;
            reset          = 1'b1;
            redirect_valid = 1'b0;
            imem_rvalid    = 1'b0;
            imem_rdata     = $urandom;
            pending.delete();
            restart(RV);
        end else begin
            reset = 1'b0;
            if (pending.size() > 0 && $urandom_range(99) < rv_pct) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pending[0]);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            if (redir_now || $urandom_range(999) < redir_permil) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_now ? redir_addr : $urandom;
                redir_now      = 1'b0;
                restart({redirect_pc[31:2], 2'b00});
            end else begin
                redirect_valid = 1'b0;
                redirect_pc    = $urandom;
            end
            if (rst_permil > 0 && $urandom_range(999) < rst_permil)
                rst_cycles = $urandom_range(2, 1);
        end
        topup();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_cycles = n;
        repeat (n) cycle();
    endtask

    // Monitor: bus observation and scoreboard comparison on the falling edge.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_imem_req", 32'(imem_req), 32'd0);
        end else begin
            if (redirect_valid) begin
                check("redir_imem_req", 32'(imem_req), 32'd0);
                check("redir_instr_valid", 32'(instr_valid), 32'd0);
            end
            if (imem_req)
                check("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (imem_req && imem_gnt) begin
                check("inflight_bound", 32'(pending.size() < DEPTH), 32'd1);
                pending.push_back(imem_addr);
            end
            if (prev_valid && !prev_ready && !redirect_valid) begin
                check("hold_valid", 32'(instr_valid), 32'd1);
                check("hold_pc", instr_pc, prev_pc);
                check("hold_instr", instr, prev_instr);
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got pc %h want no output", instr_pc);
                end else begin
                    e_head = exp_q.pop_front();
                    check("pop_pc", instr_pc, e_head.pc);
                    check("pop_instr", instr, e_head.data);
                    pops++;
                end
            end
        end
        if (imem_rvalid && pending.size() > 0)
            void'(pending.pop_front());
        prev_valid = instr_valid && !reset;
        prev_ready = instr_ready;
        prev_pc    = instr_pc;
        prev_instr = instr;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          first_g;
        int          first_v;
        int          ng;
        logic [31:0] ga [3];

        restart(RV);
        topup();

        // Streaming from reset with address wrap and two-cycle first-word latency.
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        do_reset(2);
        first_g = -1; first_v = -1; ng = 0;
        ga[0] = '1; ga[1] = '1; ga[2] = '1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (imem_req && imem_gnt) begin
                if (ng < 3) ga[ng] = imem_addr;
                if (first_g < 0) first_g = c;
                ng++;
            end
            if (instr_valid && first_v < 0) first_v = c;
        end
        check("first_valid_latency", 32'(first_v - first_g), 32'd2);
        check("wrap_addr0", ga[0], 32'hFFFF_FFF8);
        check("wrap_addr1", ga[1], 32'hFFFF_FFFC);
        check("wrap_addr2", ga[2], 32'h0000_0000);

        // Core stalled: exactly DEPTH grants, then head held on the reset vector.
        rdy_pct = 0;
        do_reset(1);
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (imem_req && imem_gnt) ng++;
        end
        check("full_grants", 32'(ng), DEPTH);
        check("full_req_low", 32'(imem_req), 32'd0);
        check("full_head_valid", 32'(instr_valid), 32'd1);
        check("full_head_pc", instr_pc, RV);
        rdy_pct = 100;
        repeat (10) cycle();

        // Redirect with two requests in flight.
        rv_pct = 0;
        do_reset(1);
        repeat (2) cycle();
        redir_now = 1'b1; redir_addr = 32'h0000_0100;
        cycle();
        rv_pct = 100;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (instr_valid) break;
        end
        check("redir_seen_valid", 32'(instr_valid), 32'd1);
        check("redir_head_pc", instr_pc, 32'h0000_0100);
        check("redir_head_instr", instr, mem_word(32'h0000_0100));

        // Misaligned redirect target.
        redir_now = 1'b1; redir_addr = 32'h0000_0102;
        cycle();
        cycle();
        check("redir_align_addr", imem_addr, 32'h0000_0100);
        repeat (8) cycle();

        // Reset with a partly full FIFO and requests in flight.
        rdy_pct = 0; rv_pct = 100;
        do_reset(1);
        repeat (3) cycle();
        rv_pct = 0;
        repeat (3) cycle();
        do_reset(1);
        rv_pct = 100;
        cycle();
        check("post_rst_valid", 32'(instr_valid), 32'd0);
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, RV);
        rdy_pct = 100;
        repeat (10) cycle();

        // Redirect coinciding with rvalid and a ready core.
        do_reset(1);
        repeat (5) cycle();
        redir_now = 1'b1; redir_addr = 32'h0000_0200;
        cycle();
        check("redir_pop_blocked", 32'(instr_valid), 32'd0);
        repeat (10) cycle();

        // Random traffic, redirects and occasional resets.
        for (int blk = 0; blk < 15; blk++) begin
            gnt_pct      = $urandom_range(100, 20);
            rv_pct       = $urandom_range(100, 20);
            rdy_pct      = $urandom_range(100, 10);
            redir_permil = $urandom_range(40, 0);
            rst_permil   = $urandom_range(5, 0);
            repeat (200) cycle();
        end
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100; redir_permil = 0; rst_permil = 0;
        repeat (20) cycle();
        check("liveness_pops", 32'(pops > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
